// File: rtl/udp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : udp_pkg
//  Purpose  : Shared types and constants for the UDP receive sequencer:
//             sequencer state encoding, UDP header size and the end-of-packet
//             status codes reported on err_code.
//  Revision : 1.0  initial release
// ============================================================================
package udp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        FWD  = 2'd2,
        DROP = 2'd3
    } udp_seq_state_t;

    localparam int UDP_HDR_BYTES = 8;

    localparam logic [1:0] ERR_OK    = 2'd0;
    localparam logic [1:0] ERR_SHORT = 2'd1;
    localparam logic [1:0] ERR_LONG  = 2'd2;
    localparam logic [1:0] ERR_LEN   = 2'd3;

endpackage
`default_nettype wire

// File: rtl/udp_hdr_capture.sv
`default_nettype none
// ============================================================================
//  Module   : udp_hdr_capture
//  Purpose  : Counts header bytes and shifts the big-endian UDP header fields
//             (source port, destination port, length) into registers. The
//             checksum bytes are counted but not stored.
//  Ports    : clk, rst_n          clock / async active-low reset
//             i_hdr_beat          accepted beat belonging to the header phase
//             i_in_last           frame ends on this beat (restarts the count)
//             i_data              stream byte
//             o_hdr_done_beat     current beat is header byte 7
//             o_src_port/o_dst_port/o_udp_length  captured fields
//  Revision : 1.0  initial release
// ============================================================================
module udp_hdr_capture (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_hdr_beat,
    input  logic        i_in_last,
    input  logic [7:0]  i_data,
    output logic        o_hdr_done_beat,
    output logic [15:0] o_src_port,
    output logic [15:0] o_dst_port,
    output logic [15:0] o_udp_length
);

    logic [2:0]  r_hdr_cnt;
    logic [15:0] r_src_port;
    logic [15:0] r_dst_port;
    logic [15:0] r_udp_length;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hdr_cnt    <= 3'd0;
            r_src_port   <= 16'd0;
            r_dst_port   <= 16'd0;
            r_udp_length <= 16'd0;
        end else if (i_hdr_beat) begin
            // A truncated header restarts at byte 0; after byte 7 the 3-bit
            // count wraps to 0 on its own, ready for the next packet.
            r_hdr_cnt <= i_in_last ? 3'd0 : r_hdr_cnt + 3'd1;
            case (r_hdr_cnt)
                3'd0:    r_src_port[15:8]   <= i_data;
                3'd1:    r_src_port[7:0]    <= i_data;
                3'd2:    r_dst_port[15:8]   <= i_data;
                3'd3:    r_dst_port[7:0]    <= i_data;
                3'd4:    r_udp_length[15:8] <= i_data;
                3'd5:    r_udp_length[7:0]  <= i_data;
                default: ;
            endcase
        end
    end

    assign o_hdr_done_beat = i_hdr_beat && (r_hdr_cnt == 3'd7);
    assign o_src_port      = r_src_port;
    assign o_dst_port      = r_dst_port;
    assign o_udp_length    = r_udp_length;

endmodule
`default_nettype wire

// File: rtl/udp_rx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : udp_rx_sequencer
//  Purpose  : Per-packet controller for the UDP receive path. Parses the UDP
//             header from the forwarder's input stream, filters on the
//             destination port, checks the length and steers the forwarder
//             between forward and drain. Reports per-packet status.
//  Ports    : clk, rst_n                    clock / async active-low reset
//             in_data/in_valid/in_ready/in_last   observed stream
//             cfg_port, cfg_port_en         destination port filter
//             fwd_enable, drop_enable       forwarder phase controls
//             header_done, udp_length       header-complete pulse + length
//             src_port, dst_port            captured ports
//             pkt_done, pkt_err, err_code   end-of-packet status
//  Revision : 1.0  initial release
// ============================================================================
module udp_rx_sequencer
    import udp_pkg::*;
#(
    parameter int HDR_BYTES   = UDP_HDR_BYTES,
    parameter int MAX_UDP_LEN = 1480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_ready,
    input  logic        in_last,
    input  logic [15:0] cfg_port,
    input  logic        cfg_port_en,
    output logic        fwd_enable,
    output logic        drop_enable,
    output logic        header_done,
    output logic [15:0] udp_length,
    output logic [15:0] src_port,
    output logic [15:0] dst_port,
    output logic        pkt_done,
    output logic        pkt_err,
    output logic [1:0]  err_code
);

    localparam logic [15:0] c_hdr_len = 16'(HDR_BYTES);
    localparam logic [15:0] c_max_len = 16'(MAX_UDP_LEN);

    udp_seq_state_t r_state, w_nxt_state;
    logic [15:0] r_pay_cnt, w_nxt_pay;
    logic [15:0] r_target, w_nxt_target;
    logic [1:0]  r_drop_code, w_nxt_drop_code;
    logic        r_drop_err, w_nxt_drop_err;
    logic        r_fwd_enable, r_drop_enable, r_header_done;
    logic        r_pkt_done, r_pkt_err;
    logic [1:0]  r_err_code, w_nxt_err_code;
    logic        w_nxt_hdr_done;
    logic        w_end, w_end_err;
    logic [1:0]  w_end_code;
    logic        w_dec_drop, w_dec_err;
    logic [1:0]  w_dec_code;

    logic        w_beat, w_hdr_beat, w_hdr_done_beat;
    logic        w_len_bad, w_port_miss, w_pay_final;

    assign w_beat     = in_valid && in_ready;
    assign w_hdr_beat = w_beat && ((r_state == IDLE) || (r_state == HDR));

    udp_hdr_capture u_hdr_capture (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_hdr_beat      (w_hdr_beat),
        .i_in_last       (in_last),
        .i_data          (in_data),
        .o_hdr_done_beat (w_hdr_done_beat),
        .o_src_port      (src_port),
        .o_dst_port      (dst_port),
        .o_udp_length    (udp_length)
    );

    // Length and port fields are complete by byte 5, so they are stable when
    // the decision is taken on byte 7.
    assign w_len_bad   = (udp_length < c_hdr_len) || (udp_length > c_max_len);
    assign w_port_miss = cfg_port_en && (dst_port != cfg_port);
    // target >= 1 whenever FWD is entered, so target-1 cannot underflow.
    assign w_pay_final = (r_pay_cnt == (r_target - 16'd1));

    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_pay       = r_pay_cnt;
        w_nxt_target    = r_target;
        w_nxt_drop_code = r_drop_code;
        w_nxt_drop_err  = r_drop_err;
        w_nxt_hdr_done  = 1'b0;
        w_nxt_err_code  = r_err_code;
        w_end           = 1'b0;
        w_end_err       = 1'b0;
        w_end_code      = ERR_OK;
        w_dec_drop      = 1'b0;
        w_dec_err       = 1'b0;
        w_dec_code      = ERR_OK;

        case (r_state)
            IDLE: begin
                if (w_beat) begin
                    if (in_last) begin
                        w_end = 1'b1; w_end_err = 1'b1; w_end_code = ERR_SHORT;
                    end else begin
                        w_nxt_state = HDR;
                    end
                end
            end
            HDR: begin
                if (w_beat && w_hdr_done_beat) begin
                    w_nxt_hdr_done = 1'b1;
                    w_nxt_pay      = 16'd0;
                    // Every non-forward outcome funnels through the drain
                    // path; a zero-payload packet ending here is a "drain"
                    // that finishes immediately with an OK status.
                    if (w_len_bad) begin
                        w_dec_drop = 1'b1; w_dec_err = 1'b1; w_dec_code = ERR_LEN;
                    end else if (w_port_miss) begin
                        w_dec_drop = 1'b1;
                    end else if (udp_length == c_hdr_len) begin
                        w_dec_drop = 1'b1;
                        w_dec_err  = !in_last;
                        w_dec_code = in_last ? ERR_OK : ERR_LONG;
                    end else if (in_last) begin
                        w_end = 1'b1; w_end_err = 1'b1; w_end_code = ERR_SHORT;
                    end else begin
                        w_nxt_state  = FWD;
                        w_nxt_target = udp_length - c_hdr_len;
                    end
                    if (w_dec_drop) begin
                        if (in_last) begin
                            w_end = 1'b1; w_end_err = w_dec_err; w_end_code = w_dec_code;
                        end else begin
                            w_nxt_state     = DROP;
                            w_nxt_drop_code = w_dec_code;
                            w_nxt_drop_err  = w_dec_err;
                        end
                    end
                end else if (w_beat && in_last) begin
                    w_end = 1'b1; w_end_err = 1'b1; w_end_code = ERR_SHORT;
                end
            end
            FWD: begin
                if (w_beat) begin
                    w_nxt_pay = r_pay_cnt + 16'd1;
                    if (in_last) begin
                        w_end      = 1'b1;
                        w_end_err  = !w_pay_final;
                        w_end_code = w_pay_final ? ERR_OK : ERR_SHORT;
                    end else if (w_pay_final) begin
                        // Payload complete but frame continues: drain the rest.
                        w_nxt_state     = DROP;
                        w_nxt_drop_code = ERR_LONG;
                        w_nxt_drop_err  = 1'b1;
                    end
                end
            end
            DROP: begin
                if (w_beat) begin
                    w_nxt_pay = r_pay_cnt + 16'd1;
                    if (in_last) begin
                        w_end = 1'b1; w_end_err = r_drop_err; w_end_code = r_drop_code;
                    end
                end
            end
            default: w_nxt_state = IDLE;
        endcase

        if (w_end) begin
            w_nxt_state    = IDLE;
            w_nxt_err_code = w_end_code;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_pay_cnt     <= 16'd0;
            r_target      <= 16'd0;
            r_drop_code   <= ERR_OK;
            r_drop_err    <= 1'b0;
            r_fwd_enable  <= 1'b0;
            r_drop_enable <= 1'b0;
            r_header_done <= 1'b0;
            r_pkt_done    <= 1'b0;
            r_pkt_err     <= 1'b0;
            r_err_code    <= ERR_OK;
        end else begin
            r_state       <= w_nxt_state;
            r_pay_cnt     <= w_nxt_pay;
            r_target      <= w_nxt_target;
            r_drop_code   <= w_nxt_drop_code;
            r_drop_err    <= w_nxt_drop_err;
            r_fwd_enable  <= (w_nxt_state == FWD);
            r_drop_enable <= (w_nxt_state == DROP);
            r_header_done <= w_nxt_hdr_done;
            r_pkt_done    <= w_end;
            r_pkt_err     <= w_end && w_end_err;
            r_err_code    <= w_nxt_err_code;
        end
    end

    assign fwd_enable  = r_fwd_enable;
    assign drop_enable = r_drop_enable;
    assign header_done = r_header_done;
    assign pkt_done    = r_pkt_done;
    assign pkt_err     = r_pkt_err;
    assign err_code    = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_udp_rx_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_udp_rx_sequencer
//  Purpose  : Scoreboard bench for udp_rx_sequencer. Each packet's expected
//             header fields and end status (forwarded/drained beat counts,
//             pkt_err, err_code) are derived from the packet description and
//             queued; a monitor pops and compares on header_done / pkt_done.
//  Revision : 1.0  initial release
// ============================================================================
module tb_udp_rx_sequencer;

    localparam int C_MAX = 1480;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_valid = 1'b0, in_ready = 1'b0, in_last = 1'b0;
    logic [15:0] cfg_port = 16'd0;
    logic        cfg_port_en = 1'b0;
    logic        fwd_enable, drop_enable, header_done, pkt_done, pkt_err;
    logic [15:0] udp_length, src_port, dst_port;
    logic [1:0]  err_code;

    always #5 clk = ~clk;

    udp_rx_sequencer #(.HDR_BYTES(8), .MAX_UDP_LEN(C_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .in_last(in_last), .cfg_port(cfg_port),
        .cfg_port_en(cfg_port_en), .fwd_enable(fwd_enable),
        .drop_enable(drop_enable), .header_done(header_done),
        .udp_length(udp_length), .src_port(src_port), .dst_port(dst_port),
        .pkt_done(pkt_done), .pkt_err(pkt_err), .err_code(err_code)
    );

    typedef struct { logic [15:0] src; logic [15:0] dst; logic [15:0] len; } hexp_t;
    typedef struct { int fwd; int drp; logic err; logic [1:0] code; } pexp_t;

    hexp_t hq[$];
    pexp_t pq[$];
    int    tests = 0;
    int    fails = 0;
    bit    rdy_rand = 0;
    bit    gaps = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: outcome of a packet of n bytes from its header fields alone.
    function automatic pexp_t model(input logic [15:0] dst, input logic [15:0] len,
                                    input int n, input logic [15:0] port, input logic en);
        pexp_t e;
        int p, t;
        e.fwd = 0; e.drp = 0; e.err = 1'b0; e.code = 2'd0;
        if (n < 8) begin
            e.err = 1'b1; e.code = 2'd1;
            return e;
        end
        p = n - 8;
        if (len < 8 || int'(len) > C_MAX) begin
            e.drp = p; e.err = 1'b1; e.code = 2'd3;
        end else if (en && dst != port) begin
            e.drp = p;
        end else if (len == 8) begin
            if (p > 0) begin e.drp = p; e.err = 1'b1; e.code = 2'd2; end
        end else begin
            t = int'(len) - 8;
            if (p <= t) begin
                e.fwd = p;
                if (p < t) begin e.err = 1'b1; e.code = 2'd1; end
            end else begin
                e.fwd = t; e.drp = p - t; e.err = 1'b1; e.code = 2'd2;
            end
        end
        return e;
    endfunction

    task automatic send(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                        input int n, input int nsend, input logic [15:0] port,
                        input logic en, input bit push);
        logic [7:0] b[$];
        hexp_t h;
        cfg_port = port; cfg_port_en = en;
        b = {};
        b.push_back(src[15:8]); b.push_back(src[7:0]);
        b.push_back(dst[15:8]); b.push_back(dst[7:0]);
        b.push_back(len[15:8]); b.push_back(len[7:0]);
        b.push_back(8'($urandom)); b.push_back(8'($urandom));
        for (int i = 8; i < n; i++) b.push_back(8'($urandom));
        while (b.size() > n) void'(b.pop_back());
        if (push) pq.push_back(model(dst, len, n, port, en));
        if (n >= 8 && nsend >= 8) begin
            h.src = src; h.dst = dst; h.len = len;
            hq.push_back(h);
        end
        for (int i = 0; i < nsend; i++) begin
            int tries = 0;
            bit acc;
            do begin
                in_data = b[i];
                in_last = (i == n - 1);
                if (tries >= 6) begin
                    in_valid = 1'b1; in_ready = 1'b1;
                end else begin
                    in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                    in_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
                end
                acc = in_valid && in_ready;
                @(posedge clk); #1;
                tries++;
            end while (!acc);
        end
    endtask

    // Monitor: beat counts per packet, popped/compared on status pulses.
    int fc = 0, dc = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            fc = 0; dc = 0;
        end else begin
            if (header_done) begin
                if (hq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL hdr_unexpected: actual=header_done required=none at %0t", $time);
                end else begin
                    hexp_t h;
                    h = hq.pop_front();
                    chk("hdr_udp_length", udp_length, h.len);
                    chk("hdr_src_port", src_port, h.src);
                    chk("hdr_dst_port", dst_port, h.dst);
                end
            end
            if (pkt_done) begin
                if (pq.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL pkt_unexpected: actual=pkt_done required=none at %0t", $time);
                end else begin
                    pexp_t e;
                    e = pq.pop_front();
                    chk("fwd_beats", fc, e.fwd);
                    chk("drop_beats", dc, e.drp);
                    chk("pkt_err", pkt_err, e.err);
                    chk("err_code", err_code, e.code);
                end
                fc = 0; dc = 0;
            end
            if (fwd_enable && drop_enable) begin
                tests++; fails++;
                $display("FAIL fwd_drop_overlap: actual=both required=one at %0t", $time);
            end
            if (in_valid && in_ready) begin
                if (fwd_enable) fc++;
                if (drop_enable) dc++;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, n, p;
        logic [15:0] len, dst, port;
        logic en;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {fwd_enable, drop_enable, header_done, udp_length, src_port,
                              dst_port, pkt_done, pkt_err, err_code}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        send(16'h0400, 16'h1234, 16'd12, 12, 12, 16'h1234, 1'b1, 1'b1); // good
        send(16'h0400, 16'h1235, 16'd12, 12, 12, 16'h1234, 1'b1, 1'b1); // filtered
        send(16'h0400, 16'h1234, 16'd6, 12, 12, 16'h1234, 1'b1, 1'b1);  // too short length
        send(16'h0400, 16'h1234, 16'd1481, 12, 12, 16'h1234, 1'b1, 1'b1); // too long length
        send(16'h0400, 16'h1234, 16'd12, 10, 10, 16'h1234, 1'b1, 1'b1); // early last
        send(16'h0400, 16'h1234, 16'd12, 14, 14, 16'h1234, 1'b1, 1'b1); // overlong frame
        send(16'h0400, 16'h1234, 16'd12, 6, 6, 16'h1234, 1'b1, 1'b1);   // truncated header
        send(16'h0400, 16'h1234, 16'd8, 8, 8, 16'h1234, 1'b1, 1'b1);    // header only
        send(16'h0400, 16'h1234, 16'd8, 11, 11, 16'h1234, 1'b1, 1'b1);  // header only, extra bytes
        send(16'h0001, 16'hBEEF, 16'd9, 9, 9, 16'h1234, 1'b0, 1'b1);    // filter off, 1 byte
        send(16'hA5A5, 16'h1234, 16'd1480, 1480, 1480, 16'h1234, 1'b1, 1'b1); // max length
        send(16'h0400, 16'h1234, 16'd1, 1, 1, 16'h1234, 1'b1, 1'b1);    // single byte frame

        // Reset in the middle of payload forwarding
        send(16'h0777, 16'h1234, 16'd28, 28, 11, 16'h1234, 1'b1, 1'b0);
        chk("fwd_before_reset", fwd_enable, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_async_outputs", {fwd_enable, drop_enable, header_done, udp_length, src_port,
                                    dst_port, pkt_done, pkt_err, err_code}, 64'd0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send(16'h0400, 16'h1234, 16'd12, 12, 12, 16'h1234, 1'b1, 1'b1);

        // Randomized back-to-back traffic
        for (int i = 0; i < 150; i++) begin
            rdy_rand = 1'b1;
            gaps = $urandom_range(0, 1);
            port = 16'($urandom);
            en = $urandom_range(0, 1);
            dst = ($urandom_range(0, 3) == 0) ? (port ^ 16'h0001) : port;
            k = $urandom_range(0, 9);
            if (k == 0) begin
                len = 16'($urandom_range(8, 40));
                n = $urandom_range(1, 7);
            end else if (k == 1) begin
                len = $urandom_range(0, 1) ? 16'($urandom_range(0, 7)) : 16'($urandom_range(1481, 65535));
                n = $urandom_range(9, 20);
            end else if (k == 2) begin
                len = 16'd8;
                n = $urandom_range(0, 1) ? 8 : $urandom_range(9, 12);
            end else begin
                len = 16'($urandom_range(9, 40));
                p = int'(len) - 8 + $urandom_range(0, 4) - 2;
                if (p < 1) p = 1;
                n = 8 + p;
            end
            send(16'($urandom), dst, len, n, n, port, en, 1'b1);
        end

        in_valid = 1'b0;
        in_last = 1'b0;
        begin
            int cyc = 0;
            while ((pq.size() != 0 || hq.size() != 0) && cyc < 200) begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        chk("pkt_queue_drained", pq.size(), 0);
        chk("hdr_queue_drained", hq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
